// File: rtl/fetch_queue_unit.sv
// Instruction fetch with DEPTH-entry prefetch queue; entry visible one cycle after ihit, redirect flushes.
// Fetch stalls when the queue is full or halted; decode backpressure via fq_ready. Optional perf counters: FETCH_PERF_EN.
module fetch_queue_unit #(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0,
  parameter int                DEPTH   = 4
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         ihit,
  input  logic [WORD_W-1:0]            imemload,
  output logic                         iREN,
  output logic [WORD_W-1:0]            imemaddr,
  input  logic                         redirect,
  input  logic [WORD_W-1:0]            redirect_pc,
  input  logic                         halt,
  output logic                         fq_valid,
  output logic [WORD_W-1:0]            fq_instr,
  output logic [WORD_W-1:0]            fq_pc,
  output logic [WORD_W-1:0]            fq_npc,
  input  logic                         fq_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fq_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                  perf_fetched,
  output logic [31:0]                  perf_full_cycles
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {FETCH, HALTED} state_t;

  state_t            state;
  logic [PW-1:0]     head, tail;
  logic [WORD_W-1:0] instr_mem [DEPTH];
  logic [WORD_W-1:0] pc_mem    [DEPTH];
  logic              push, pop;
  logic              unused_rpc_lsb;

  // Targets are forced word-aligned, so the low redirect bits never matter.
  assign unused_rpc_lsb = ^redirect_pc[1:0];

  assign iREN     = nRST && (state == FETCH) && (fq_count < FULL);
  assign fq_valid = (fq_count != '0) && !redirect;
  assign push     = iREN && ihit && !redirect;
  assign pop      = fq_valid && fq_ready;

  assign fq_instr = instr_mem[head];
  assign fq_pc    = pc_mem[head];
  assign fq_npc   = pc_mem[head] + WORD_W'(4);

  always_ff @(posedge CLK) begin
    if (push) begin
      instr_mem[tail] <= imemload;
      pc_mem[tail]    <= imemaddr;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= FETCH;
      imemaddr <= PC_INIT;
      head     <= '0;
      tail     <= '0;
      fq_count <= '0;
    end else if (redirect) begin
      state    <= FETCH;
      imemaddr <= {redirect_pc[WORD_W-1:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      fq_count <= '0;
    end else begin
      if (push) begin
        tail     <= tail + 1'b1;
        imemaddr <= imemaddr + WORD_W'(4);
      end
      if (pop)
        head <= head + 1'b1;
      case ({push, pop})
        2'b10:   fq_count <= fq_count + 1'b1;
        2'b01:   fq_count <= fq_count - 1'b1;
        default: fq_count <= fq_count;
      endcase
      // A word fetched alongside halt is still queued before stopping.
      if (state == FETCH && halt)
        state <= HALTED;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      perf_fetched     <= '0;
      perf_full_cycles <= '0;
    end else begin
      if (push && perf_fetched != '1)
        perf_fetched <= perf_fetched + 1'b1;
      if (state == FETCH && fq_count == FULL && perf_full_cycles != '1)
        perf_full_cycles <= perf_full_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_fetch_queue_unit;

  localparam int          D   = 4;
  localparam logic [31:0] PCI = 32'h100;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        iREN;
  logic [31:0] imemaddr;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        fq_valid;
  logic [31:0] fq_instr, fq_pc, fq_npc;
  logic        fq_ready = 1'b0;
  logic [2:0]  fq_count;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_full_cycles;
`endif

  fetch_queue_unit #(.WORD_W(32), .PC_INIT(PCI), .DEPTH(D)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .iREN(iREN),
    .imemaddr(imemaddr), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .fq_valid(fq_valid), .fq_instr(fq_instr), .fq_pc(fq_pc), .fq_npc(fq_npc),
    .fq_ready(fq_ready), .fq_count(fq_count)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_full_cycles(perf_full_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mpc;
  bit          mhalted;
  logic [31:0] m_fetched, m_full;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs at negedge, advance the model at posedge.
  task automatic step(input bit rst_n, input bit hit, input bit rd, input bit hl,
                      input bit rdy, input logic [31:0] rpc);
    bit   e_iren, e_valid, do_push, do_pop;
    ent_t e;
    nRST = rst_n; ihit = hit; imemload = $urandom; redirect = rd;
    redirect_pc = rpc; halt = hl; fq_ready = rdy;
    @(negedge CLK);
    e_iren  = rst_n && !mhalted && (q.size() < D);
    e_valid = (q.size() != 0) && !rd;
    chk("iREN", {31'b0, iREN}, {31'b0, e_iren});
    chk("fq_valid", {31'b0, fq_valid}, {31'b0, e_valid});
    chk("fq_count", 32'(fq_count), 32'(q.size()));
    chk("imemaddr", imemaddr, mpc);
    if (e_valid) begin
      chk("fq_pc", fq_pc, q[0].pc);
      chk("fq_instr", fq_instr, q[0].instr);
      chk("fq_npc", fq_npc, q[0].pc + 32'd4);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_full_cycles", perf_full_cycles, m_full);
`endif
    @(posedge CLK);
    do_push = e_iren && hit && !rd;
    do_pop  = e_valid && rdy;
    if (!rst_n) begin
      q.delete(); mpc = PCI; mhalted = 0; m_fetched = '0; m_full = '0;
    end else begin
      if (!mhalted && q.size() == D && m_full != 32'hFFFF_FFFF) m_full++;
      if (do_push && m_fetched != 32'hFFFF_FFFF) m_fetched++;
      if (rd) begin
        q.delete(); mpc = {rpc[31:2], 2'b00}; mhalted = 0;
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          e.pc = mpc; e.instr = imemload;
          q.push_back(e);
          mpc = mpc + 32'd4;
        end
        if (hl) mhalted = 1;
      end
    end
    #1;
  endtask

  initial begin
    @(posedge CLK);
    q.delete(); mpc = PCI; mhalted = 0; m_fetched = '0; m_full = '0;
    #1;
    // reset held: iREN low, queue empty, PC at PC_INIT
    repeat (2) step(0, 1, 0, 0, 1, '0);
    // streaming: ihit and ready every cycle
    repeat (8) step(1, 1, 0, 0, 1, '0);
    // fill to full with decode stalled, free one slot, then refill and drain
    repeat (7) step(1, 1, 0, 0, 0, '0);
    step(1, 0, 0, 0, 1, '0);
    repeat (3) step(1, 1, 0, 0, 0, '0);
    repeat (6) step(1, 0, 0, 0, 1, '0);
    // three entries queued, redirect with simultaneous ihit
    repeat (3) step(1, 1, 0, 0, 0, '0);
    step(1, 1, 1, 0, 1, 32'h2003);
    repeat (3) step(1, 1, 0, 0, 1, '0);
    // halt with ihit at 0x40, drain, then resume via redirect to 0x80
    step(1, 0, 1, 0, 1, 32'h40);
    step(1, 1, 0, 1, 0, '0);
    repeat (4) step(1, 1, 0, 0, 1, '0);
    step(1, 1, 1, 0, 1, 32'h80);
    repeat (3) step(1, 1, 0, 0, 1, '0);
    // PC wrap across 2^32
    step(1, 0, 1, 0, 1, 32'hFFFF_FFF8);
    repeat (3) step(1, 1, 0, 0, 0, '0);
    repeat (4) step(1, 0, 0, 0, 1, '0);
    // random traffic including occasional mid-run resets
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) != 0, $urandom_range(9) < 7, $urandom_range(19) == 0,
           $urandom_range(19) == 0, $urandom_range(9) < 6, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
